usb_tx_ctrl: RTL and testbench
==============================

# usb_tx_ctrl

Sequencing controller for the USB TX path. It sits between the AHB-lite slave's TX control register and data buffer on one side and the byte-level USB TX encoder on the other. On a packet command it emits SYNC, PID, the data bytes popped from the buffer and an optional CRC16 as a valid/ready byte stream. It reports progress (`tx_transfer_active`) and failures (`tx_error`) back to the slave's status and error registers.

## Interface
- `MAX_PKT`, default 64: maximum data payload in bytes.
- `TIMEOUT`, default 255: maximum consecutive stall cycles (`enc_valid`=1, `enc_ready`=0) before abort.

- `clk`  in  1  system clock; single clock domain.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `tx_packet`  in  3  command from TX control register: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6–7 invalid.
- `buffer_occupancy`  in  7  bytes currently held in the data buffer.
- `tx_packet_data`  in  8  head byte of the data buffer (show-ahead).
- `get_tx_packet_data`  out  1  pop strobe to the data buffer; one byte per high cycle.
- `enc_ready`  in  1  encoder accepts `enc_byte` this cycle.
- `enc_valid`  out  1  `enc_byte` is valid.
- `enc_byte`  out  8  byte to encoder, LSB transmitted first.
- `enc_eop`  out  1  marks the current byte as last of packet; valid only with `enc_valid`.
- `enc_abort`  out  1  one-cycle pulse; encoder drops the packet in progress.
- `tx_transfer_active`  out  1  packet in progress.
- `tx_error`  out  1  one-cycle error pulse.

## Operation
- A transfer is one byte crossing the interface, defined as `enc_valid & enc_ready` at a rising edge. `enc_byte` and `enc_eop` hold stable while `enc_valid=1` and `enc_ready=0`.
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, ERR, REARM.
- IDLE, `tx_packet`=0: stay in IDLE.
- IDLE, `tx_packet` in 1–5: latch the command.
  - For DATA0/DATA1, also latch `len = buffer_occupancy`.
  - Go to SYNC.
- IDLE, `tx_packet` in 6–7, or DATA command with `buffer_occupancy > MAX_PKT`: go to ERR. No byte is emitted.
- SYNC: `enc_byte`=8'h80. On transfer, go to PID.
- PID bytes: DATA0 8'hC3, DATA1 8'h4B, ACK 8'hD2, NAK 8'h5A, STALL 8'h1E.
  - `enc_eop`=1 for ACK/NAK/STALL.
  - `enc_eop`=1 for a data packet with `len`=0 and CRC compiled out.
  - On PID transfer, the CRC register loads 16'hFFFF.
- After the PID transfer:
  - handshake packet → REARM.
  - data packet with `len`>0 → DATA.
  - data packet with `len`=0 → CRC_LO, or REARM when CRC is compiled out.
- DATA: `enc_byte = tx_packet_data`.
  - `get_tx_packet_data` is high exactly in transfer cycles.
  - Each transfer decrements the remaining count.
  - `enc_eop`=1 on the final byte when CRC is compiled out.
  - After the final byte: go to CRC_LO, or REARM when CRC is compiled out.
- DATA with `buffer_occupancy`=0 and bytes still remaining (underflow): `enc_valid`=0 and go to ERR.
- CRC16 update per data byte (USB CRC16, reflected):
  - 8 iterations, LSB first.
  - Each iteration: `crc = (crc>>1) ^ ((crc[0]^bit) ? 16'hA001 : 0)`.
- CRC_LO sends `~crc[7:0]`. CRC_HI sends `~crc[15:8]` with `enc_eop`=1, then goes to REARM.
- Stall counter:
  - Increments each cycle with `enc_valid=1` and `enc_ready=0`.
  - Clears on any transfer.
  - Reaching `TIMEOUT` → ERR.
- ERR lasts one cycle.
  - `tx_error`=1.
  - `enc_abort`=1, only if SYNC had already transferred.
  - Then go to REARM.
- REARM: wait until `tx_packet`=0 is sampled, then go to IDLE. A command held high never retriggers.
- `tx_transfer_active` is 1 in SYNC, PID, DATA, CRC_LO, CRC_HI and ERR; 0 in IDLE and REARM.

## Timing
- Reset (async assert) values:
  - state IDLE, counters 0, CRC 16'hFFFF.
  - `enc_byte`=0; `enc_valid`, `enc_eop`, `enc_abort`, `get_tx_packet_data`, `tx_transfer_active`, `tx_error` all 0.
- Reset mid-packet returns to IDLE immediately. No abort pulse is issued.
- Command sampled at edge k → `enc_valid`=1 with SYNC in cycle k+1.
- With `enc_ready` tied to 1:
  - handshake packet: 2 cycles.
  - data packet: 2+`len`+2 cycles; 2+`len` without CRC.
- `tx_transfer_active` falls in the cycle after the EOP byte transfers.
- The pop takes effect at the same edge as the transfer. The buffer must present the next head byte in the following cycle.
- `len` is latched once at the start. Writes to the buffer during the packet do not change the length.

## Configuration
- `USB_TX_CRC16_EN` defined:
  - CRC16 is computed and appended; CRC_LO and CRC_HI are reachable.
  - EOP is on CRC_HI.
- Not defined:
  - no CRC logic; CRC_LO and CRC_HI are unreachable.
  - EOP is on the last data byte, or on PID when `len`=0.
  - The bench disables CRC checks.

## Test plan
- ACK command, `enc_ready`=1 → bytes 80,D2 (EOP on D2). `tx_transfer_active` high 2 cycles. `tx_error` never asserts.
- DATA0 with empty buffer, CRC on → bytes 80,C3,00,00 with EOP on the last byte; zero pops.
- DATA1, buffer {01,02,03,04}, random `enc_ready` gaps → bytes 80,4B,01,02,03,04,CRC. The CRC matches the reference model. Exactly 4 pops, all on transfer edges.
- `tx_packet`=7 → one-cycle `tx_error`, no `enc_valid`. Holding `tx_packet`=7 produces no second error until it is returned to 0.
- DATA0 with `len`=3 and occupancy forced to 0 after the first byte → `tx_error` and `enc_abort` pulse, then IDLE once `tx_packet`=0.
- `enc_ready` held low for 255 cycles during PID → timeout: `tx_error`+`enc_abort`. `n_rst` pulsed mid-DATA → all outputs 0 asynchronously.

Source files
------------

// File: rtl/usb_tx_ctrl.sv
// -----------------------------------------------------------------------------
// usb_tx_ctrl
//   Sequencing controller for the USB TX path. On a packet command from the TX
//   control register it streams SYNC, PID, the payload popped from the data
//   buffer and (optionally) a CRC16 to the byte-level encoder over a
//   valid/ready interface, and reports progress and errors back to the slave.
//
//   Optional feature macro: USB_TX_CRC16_EN
//     defined     -> CRC16 computed over the payload and appended (EOP on CRC_HI)
//     not defined -> no CRC; EOP on the last data byte, or on PID when len = 0
//
// Parameters
//   MAX_PKT  maximum payload length in bytes
//   TIMEOUT  consecutive stall cycles (enc_valid=1, enc_ready=0) before abort
//
// Ports
//   clk                 system clock
//   n_rst               asynchronous active-low reset
//   tx_packet[2:0]      command: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL
//   buffer_occupancy    bytes currently held in the data buffer
//   tx_packet_data      head byte of the data buffer (show-ahead)
//   get_tx_packet_data  pop strobe, high exactly in payload transfer cycles
//   enc_ready           encoder accepts enc_byte this cycle
//   enc_valid           enc_byte is valid
//   enc_byte            byte to encoder (LSB transmitted first)
//   enc_eop             current byte is the last of the packet
//   enc_abort           one-cycle pulse: encoder drops the packet in progress
//   tx_transfer_active  packet in progress
//   tx_error            one-cycle error pulse
// -----------------------------------------------------------------------------
module usb_tx_ctrl #(
   parameter int MAX_PKT = 64,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] tx_packet,
   input  logic [6:0] buffer_occupancy,
   input  logic [7:0] tx_packet_data,
   output logic       get_tx_packet_data,
   input  logic       enc_ready,
   output logic       enc_valid,
   output logic [7:0] enc_byte,
   output logic       enc_eop,
   output logic       enc_abort,
   output logic       tx_transfer_active,
   output logic       tx_error
);

`ifdef USB_TX_CRC16_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   localparam int               STALL_W   = $clog2(TIMEOUT + 1);
   localparam logic [STALL_W-1:0] TIMEOUT_W = STALL_W'(TIMEOUT);
   localparam logic [7:0]       MAX_PKT_W = 8'(MAX_PKT);

   localparam logic [2:0] CMD_DATA0 = 3'd1;
   localparam logic [2:0] CMD_DATA1 = 3'd2;
   localparam logic [2:0] CMD_STALL = 3'd5;

   typedef enum logic [2:0] {
      IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, ERR, REARM
   } state_t;

   state_t             state_reg, state_next;
   logic [2:0]         cmd_reg, cmd_next;
   logic [6:0]         remain_reg, remain_next;
   logic [STALL_W-1:0] stall_reg, stall_next;
   logic               synced_reg, synced_next;   // SYNC has crossed the interface

   logic               cmd_is_data;
   logic               req_is_data;
   logic [7:0]         pid_byte;
   logic [STALL_W-1:0] stall_inc;

   assign cmd_is_data = (cmd_reg == CMD_DATA0) || (cmd_reg == CMD_DATA1);
   assign req_is_data = (tx_packet == CMD_DATA0) || (tx_packet == CMD_DATA1);
   assign stall_inc   = stall_reg + STALL_W'(1);

   always_comb begin
      pid_byte = 8'h00;
      case (cmd_reg)
         3'd1:    pid_byte = 8'hC3;
         3'd2:    pid_byte = 8'h4B;
         3'd3:    pid_byte = 8'hD2;
         3'd4:    pid_byte = 8'h5A;
         3'd5:    pid_byte = 8'h1E;
         default: pid_byte = 8'h00;
      endcase
   end

`ifdef USB_TX_CRC16_EN
   // Reflected USB CRC16, one stage per payload bit, LSB first.
   logic [15:0] crc_reg;
   logic [15:0] crc_stage [0:8];

   assign crc_stage[0] = crc_reg;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
         assign crc_stage[gi+1] = (crc_stage[gi] >> 1) ^
                                  ((crc_stage[gi][0] ^ tx_packet_data[gi]) ? 16'hA001 : 16'h0000);
      end
   endgenerate

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         crc_reg <= 16'hFFFF;
      end else if (state_reg == PID && enc_ready) begin
         crc_reg <= 16'hFFFF;
      end else if (get_tx_packet_data) begin
         crc_reg <= crc_stage[8];
      end
   end
`endif

   always_comb begin
      state_next         = state_reg;
      cmd_next           = cmd_reg;
      remain_next        = remain_reg;
      synced_next        = synced_reg;
      stall_next         = stall_reg;
      enc_valid          = 1'b0;
      enc_byte           = 8'h00;
      enc_eop            = 1'b0;
      enc_abort          = 1'b0;
      tx_error           = 1'b0;
      get_tx_packet_data = 1'b0;
      tx_transfer_active = 1'b0;

      case (state_reg)
         IDLE: begin
            synced_next = 1'b0;
            if (tx_packet != 3'd0) begin
               if (tx_packet > CMD_STALL) begin
                  state_next = ERR;
               end else if (req_is_data && ({1'b0, buffer_occupancy} > MAX_PKT_W)) begin
                  state_next = ERR;
               end else begin
                  cmd_next    = tx_packet;
                  remain_next = req_is_data ? buffer_occupancy : 7'd0;
                  state_next  = SYNC;
               end
            end
         end

         SYNC: begin
            tx_transfer_active = 1'b1;
            enc_valid          = 1'b1;
            enc_byte           = 8'h80;
            if (enc_ready) begin
               synced_next = 1'b1;
               state_next  = PID;
            end
         end

         PID: begin
            tx_transfer_active = 1'b1;
            enc_valid          = 1'b1;
            enc_byte           = pid_byte;
            enc_eop            = !cmd_is_data || (remain_reg == 7'd0 && !CRC_EN);
            if (enc_ready) begin
               if (!cmd_is_data)
                  state_next = REARM;
               else if (remain_reg != 7'd0)
                  state_next = DATA;
               else
                  state_next = CRC_EN ? CRC_LO : REARM;
            end
         end

         DATA: begin
            tx_transfer_active = 1'b1;
            if (buffer_occupancy == 7'd0) begin
               // Buffer ran dry with payload still owed: abandon the packet.
               state_next = ERR;
            end else begin
               enc_valid = 1'b1;
               enc_byte  = tx_packet_data;
               enc_eop   = !CRC_EN && (remain_reg == 7'd1);
               if (enc_ready) begin
                  get_tx_packet_data = 1'b1;
                  remain_next        = remain_reg - 7'd1;
                  if (remain_reg == 7'd1)
                     state_next = CRC_EN ? CRC_LO : REARM;
               end
            end
         end

`ifdef USB_TX_CRC16_EN
         CRC_LO: begin
            tx_transfer_active = 1'b1;
            enc_valid          = 1'b1;
            enc_byte           = ~crc_reg[7:0];
            if (enc_ready)
               state_next = CRC_HI;
         end

         CRC_HI: begin
            tx_transfer_active = 1'b1;
            enc_valid          = 1'b1;
            enc_byte           = ~crc_reg[15:8];
            enc_eop            = 1'b1;
            if (enc_ready)
               state_next = REARM;
         end
`endif

         ERR: begin
            tx_transfer_active = 1'b1;
            tx_error           = 1'b1;
            enc_abort          = synced_reg;
            state_next         = REARM;
         end

         REARM: begin
            // A command left asserted must not start another packet.
            if (tx_packet == 3'd0)
               state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase

      // Stall watchdog: only byte-offering cycles that the encoder refuses count.
      if (enc_valid && !enc_ready) begin
         if (stall_inc == TIMEOUT_W) begin
            state_next = ERR;
            stall_next = '0;
         end else begin
            stall_next = stall_inc;
         end
      end else begin
         stall_next = '0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg  <= IDLE;
         cmd_reg    <= 3'd0;
         remain_reg <= 7'd0;
         stall_reg  <= '0;
         synced_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cmd_reg    <= cmd_next;
         remain_reg <= remain_next;
         stall_reg  <= stall_next;
         synced_reg <= synced_next;
      end
   end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_ctrl
//   Self-checking bench for usb_tx_ctrl. Packets are described as the byte
//   list the encoder should see (SYNC, PID, payload, CRC); a queue models the
//   show-ahead data buffer. Directed steps cover rejects, underflow, timeout
//   and asynchronous reset; a randomized loop covers mixed packets with random
//   encoder back-pressure.
// -----------------------------------------------------------------------------
module tb_usb_tx_ctrl;

`ifdef USB_TX_CRC16_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       n_rst;
   logic [2:0] tx_packet;
   logic [6:0] buffer_occupancy;
   logic [7:0] tx_packet_data;
   logic       get_tx_packet_data;
   logic       enc_ready;
   logic       enc_valid;
   logic [7:0] enc_byte;
   logic       enc_eop;
   logic       enc_abort;
   logic       tx_transfer_active;
   logic       tx_error;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] buf_q [$];

   usb_tx_ctrl #(.MAX_PKT(64), .TIMEOUT(255)) dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .tx_packet          (tx_packet),
      .buffer_occupancy   (buffer_occupancy),
      .tx_packet_data     (tx_packet_data),
      .get_tx_packet_data (get_tx_packet_data),
      .enc_ready          (enc_ready),
      .enc_valid          (enc_valid),
      .enc_byte           (enc_byte),
      .enc_eop            (enc_eop),
      .enc_abort          (enc_abort),
      .tx_transfer_active (tx_transfer_active),
      .tx_error           (tx_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pid_of(input logic [2:0] cmd);
      case (cmd)
         3'd1:    return 8'hC3;
         3'd2:    return 8'h4B;
         3'd3:    return 8'hD2;
         3'd4:    return 8'h5A;
         default: return 8'h1E;
      endcase
   endfunction

   // USB CRC16 over a byte list, bit by bit, LSB first.
   function automatic logic [15:0] crc16(input logic [7:0] q [$]);
      logic [15:0] c = 16'hFFFF;
      foreach (q[i]) begin
         for (int j = 0; j < 8; j++) begin
            if (c[0] ^ q[i][j]) c = (c >> 1) ^ 16'hA001;
            else                c = c >> 1;
         end
      end
      return c;
   endfunction

   task automatic drive_buf();
      buffer_occupancy = 7'(buf_q.size());
      tx_packet_data   = (buf_q.size() != 0) ? buf_q[0] : 8'h00;
   endtask

   task automatic fill_buf(input int len);
      buf_q.delete();
      for (int i = 0; i < len; i++) buf_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // Runs one well-formed packet from IDLE back to IDLE; entered and left at posedge+1.
   task automatic run_pkt(input logic [2:0] cmd, input int ready_pct);
      logic [7:0]  exp_q [$];
      logic [15:0] c;
      int          idx = 0;
      int          cyc = 0;
      int          len;
      bit          is_data, xfer, pop;
      is_data = (cmd == 3'd1) || (cmd == 3'd2);
      len     = is_data ? buf_q.size() : 0;
      exp_q.push_back(8'h80);
      exp_q.push_back(pid_of(cmd));
      if (is_data) begin
         foreach (buf_q[i]) exp_q.push_back(buf_q[i]);
         if (CRC_EN) begin
            c = crc16(buf_q);
            exp_q.push_back(~c[7:0]);
            exp_q.push_back(~c[15:8]);
         end
      end
      drive_buf();
      tx_packet = cmd;
      @(posedge clk);
      #1 tx_packet = 3'd0;
      while (idx < exp_q.size() && cyc < 400) begin
         enc_ready = ($urandom_range(0, 99) < ready_pct);
         @(negedge clk);
         cyc++;
         check("active", 32'(tx_transfer_active), 32'd1);
         check("err_abort", 32'({tx_error, enc_abort}), 32'd0);
         check("valid", 32'(enc_valid), 32'd1);
         check($sformatf("byte[%0d]", idx), 32'(enc_byte), 32'(exp_q[idx]));
         check($sformatf("eop[%0d]", idx), 32'(enc_eop), 32'(idx == exp_q.size() - 1));
         xfer = enc_valid && enc_ready;
         pop  = xfer && (idx >= 2) && (idx < 2 + len);
         check("pop", 32'(get_tx_packet_data), 32'(pop));
         @(posedge clk);
         #1;
         if (pop) void'(buf_q.pop_front());
         drive_buf();
         if (xfer) idx++;
      end
      check("completed", 32'(idx), 32'(exp_q.size()));
      if (ready_pct >= 100) check("pkt_cycles", 32'(cyc), 32'(exp_q.size()));
      $display("pkt cmd=%0d len=%0d ready%%=%0d cycles=%0d bytes=%0d", cmd, len, ready_pct, cyc, idx);
      @(negedge clk);
      check("active_after_eop", 32'(tx_transfer_active), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Command that must be refused: one error pulse, no byte, no abort, no retrigger.
   task automatic expect_reject(input logic [2:0] cmd, input string tag);
      drive_buf();
      tx_packet = cmd;
      enc_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_error"}, 32'(tx_error), 32'd1);
      check({tag, "_abort"}, 32'(enc_abort), 32'd0);
      check({tag, "_valid"}, 32'(enc_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check({tag, "_held"}, 32'({tx_error, enc_valid, tx_transfer_active}), 32'd0);
      end
      @(posedge clk);
      #1 tx_packet = 3'd0;
      @(posedge clk);
      #1;
      $display("reject %s cmd=%0d occupancy=%0d", tag, cmd, buffer_occupancy);
   endtask

   initial begin
      int bad;
      logic [2:0] rcmd;
      n_rst     = 1'b0;
      tx_packet = 3'd0;
      enc_ready = 1'b0;
      buf_q.delete();
      drive_buf();
      #12;
      check("reset_outputs", 32'({enc_valid, enc_eop, enc_abort, get_tx_packet_data,
                                  tx_transfer_active, tx_error}), 32'd0);
      check("reset_byte", 32'(enc_byte), 32'd0);
      @(posedge clk);
      #1 n_rst = 1'b1;

      // Handshake with free-running encoder.
      run_pkt(3'd3, 100);

      // Empty data packet.
      buf_q.delete();
      run_pkt(3'd1, 100);

      // DATA1 with 4 bytes and back-pressure.
      buf_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_pkt(3'd2, 50);

      // Largest legal payload.
      fill_buf(64);
      run_pkt(3'd1, 100);

      // Invalid commands and oversize payload.
      buf_q.delete();
      expect_reject(3'd7, "cmd7");
      expect_reject(3'd6, "cmd6");
      fill_buf(65);
      expect_reject(3'd2, "oversize");
      buf_q.delete();
      drive_buf();
      run_pkt(3'd4, 100);

      // Buffer underflow after the first payload byte.
      buf_q = '{8'hA5, 8'h5A, 8'h3C};
      drive_buf();
      enc_ready = 1'b1;
      tx_packet = 3'd1;
      @(posedge clk);
      #1 tx_packet = 3'd0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("uf_first_byte", 32'(enc_byte), 32'hA5);
      check("uf_first_pop", 32'(get_tx_packet_data), 32'd1);
      @(posedge clk);
      #1 buffer_occupancy = 7'd0;
      @(negedge clk);
      check("uf_valid", 32'(enc_valid), 32'd0);
      check("uf_pop", 32'(get_tx_packet_data), 32'd0);
      @(negedge clk);
      check("uf_error", 32'(tx_error), 32'd1);
      check("uf_abort", 32'(enc_abort), 32'd1);
      @(negedge clk);
      check("uf_rearm", 32'({tx_error, enc_abort, tx_transfer_active}), 32'd0);
      @(posedge clk);
      #1;
      buf_q.delete();
      drive_buf();
      $display("underflow step done");

      // Encoder stalls through the PID byte until the watchdog fires.
      tx_packet = 3'd3;
      enc_ready = 1'b1;
      @(posedge clk);
      #1 tx_packet = 3'd0;
      @(posedge clk);
      #1 enc_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         if (!(enc_valid === 1'b1 && tx_error === 1'b0 && enc_byte === 8'hD2)) bad++;
         @(posedge clk);
      end
      check("stall_hold", 32'(bad), 32'd0);
      @(negedge clk);
      check("timeout_error", 32'(tx_error), 32'd1);
      check("timeout_abort", 32'(enc_abort), 32'd1);
      check("timeout_valid", 32'(enc_valid), 32'd0);
      enc_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      $display("timeout step done");

      // Asynchronous reset in the middle of the payload.
      buf_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      drive_buf();
      tx_packet = 3'd1;
      @(posedge clk);
      #1 tx_packet = 3'd0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_valid", 32'(enc_valid), 32'd1);
      check("rst_mid_byte", 32'(enc_byte), 32'h11);
      #2 n_rst = 1'b0;
      #1;
      check("rst_async_outputs", 32'({enc_valid, enc_eop, enc_abort, get_tx_packet_data,
                                      tx_transfer_active, tx_error}), 32'd0);
      check("rst_async_byte", 32'(enc_byte), 32'd0);
      @(posedge clk);
      #1 n_rst = 1'b1;
      buf_q.delete();
      drive_buf();
      $display("reset step done");

      // Randomized packets with random back-pressure.
      for (int n = 0; n < 8; n++) begin
         rcmd = 3'($urandom_range(1, 5));
         if (rcmd == 3'd1 || rcmd == 3'd2) fill_buf($urandom_range(0, 20));
         else buf_q.delete();
         run_pkt(rcmd, $urandom_range(30, 100));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
